// File: rtl/instr_pipe_reg.sv
// instr_pipe_reg: elastic, DEPTH-slot pipeline register for decoded
// instruction fields (format, opcode, sign, operand, immediate).
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high on the same interface. in_ready is combinational from the
// slot valids, out_ready, flush and reset. It never depends on in_valid.
// out_valid and out_* come straight from registers.
//
// Optional feature: define INSTR_PIPE_REG_STATS_EN to add the saturating
// stall_count / flush_count outputs.

module instr_pipe_reg #(
    parameter int DEPTH     = 1,
    parameter int OPCODE_W  = 4,
    parameter int OPERAND_W = 3,
    parameter int IMM_W     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_format,
    input  logic [OPCODE_W-1:0]  in_opcode,
    input  logic                 in_sign,
    input  logic [OPERAND_W-1:0] in_operand,
    input  logic [IMM_W-1:0]     in_immediate,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_format,
    output logic [OPCODE_W-1:0]  out_opcode,
    output logic                 out_sign,
    output logic [OPERAND_W-1:0] out_operand,
    output logic [IMM_W-1:0]     out_immediate
`ifdef INSTR_PIPE_REG_STATS_EN
    ,
    output logic [15:0]          stall_count,
    output logic [7:0]           flush_count
`endif
);

    // Packed slot word layout, MSB first: format, opcode, sign, operand, immediate.
    localparam int W = 2 + OPCODE_W + OPERAND_W + IMM_W;

    logic [W-1:0]     r_data [DEPTH];
    logic [DEPTH-1:0] r_v;

    logic [DEPTH-1:0] w_adv;
    logic             w_accept;
    logic [W-1:0]     w_in_data;
    logic [W-1:0]     w_out_data;

    assign w_in_data = {in_format, in_opcode, in_sign, in_operand, in_immediate};

    // Slot i may advance when the downstream takes the last slot or any slot
    // from i onward is empty. This is the unrolled adv[i] = !v[i] | adv[i+1].
    always_comb begin
        w_adv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_adv[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!r_v[j]) begin
                    w_adv[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = w_adv[0] & ~flush & ~reset;
    assign w_accept = in_valid & in_ready;

    // Slot shifting. Bubbles collapse forward, and flush clears every valid.
    // A transfer out of the last slot on a flush cycle still completes,
    // because the downstream samples out_valid & out_ready at this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_v[0] <= w_accept;
                if (w_accept) begin
                    r_data[0] <= w_in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_v[i]    <= r_v[i-1];
                    r_data[i] <= r_data[i-1];
                end
            end
            if (flush) begin
                r_v <= '0;
            end
        end
    end

    // Output fields are masked to zero whenever the last slot is empty.
    assign out_valid  = r_v[DEPTH-1];
    assign w_out_data = r_v[DEPTH-1] ? r_data[DEPTH-1] : '0;

    assign out_format    = w_out_data[W-1];
    assign out_opcode    = w_out_data[IMM_W+OPERAND_W+1 +: OPCODE_W];
    assign out_sign      = w_out_data[IMM_W+OPERAND_W];
    assign out_operand   = w_out_data[IMM_W +: OPERAND_W];
    assign out_immediate = w_out_data[IMM_W-1:0];

`ifdef INSTR_PIPE_REG_STATS_EN
    logic [15:0] r_stall_count;
    logic [7:0]  r_flush_count;

    // Saturating counters: stalled output cycles and flushes that discard work.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (flush && (|r_v) && (r_flush_count != 8'hFF)) begin
                r_flush_count <= r_flush_count + 8'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_instr_pipe_reg.sv
// Directed bench for instr_pipe_reg with DEPTH=3. Each expected value is
// worked out by hand from the slot-advance rules. A scoreboard queue holds
// the words accepted upstream and checks that they leave in order.
// The counter tests are built only when INSTR_PIPE_REG_STATS_EN is defined.

module tb_instr_pipe_reg;

    localparam int DEPTH = 3;
    localparam int W     = 17;

    logic       clock;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic       in_format;
    logic [3:0] in_opcode;
    logic       in_sign;
    logic [2:0] in_operand;
    logic [7:0] in_immediate;
    logic       out_valid;
    logic       out_ready;
    logic       out_format;
    logic [3:0] out_opcode;
    logic       out_sign;
    logic [2:0] out_operand;
    logic [7:0] out_immediate;
`ifdef INSTR_PIPE_REG_STATS_EN
    logic [15:0] stall_count;
    logic [7:0]  flush_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    instr_pipe_reg #(
        .DEPTH(DEPTH), .OPCODE_W(4), .OPERAND_W(3), .IMM_W(8)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_format(in_format), .in_opcode(in_opcode), .in_sign(in_sign),
        .in_operand(in_operand), .in_immediate(in_immediate),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_format(out_format), .out_opcode(out_opcode), .out_sign(out_sign),
        .out_operand(out_operand), .out_immediate(out_immediate)
`ifdef INSTR_PIPE_REG_STATS_EN
        ,
        .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    // Clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Build an instruction word from an opcode so each field differs per op.
    function automatic logic [W-1:0] make_word(input logic [3:0] op);
        logic [7:0] imm;
        imm = {op, ~op};
        return {op[0], op, op[1], op[2:0], imm};
    endfunction

    function automatic logic [W-1:0] out_word();
        return {out_format, out_opcode, out_sign, out_operand, out_immediate};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [3:0] op);
        logic [W-1:0] w;
        w = make_word(op);
        in_valid     = v;
        in_format    = w[16];
        in_opcode    = w[15:12];
        in_sign      = w[11];
        in_operand   = w[10:8];
        in_immediate = w[7:0];
    endtask

    // Scoreboard: every output transfer must match the oldest expected word.
    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            logic [W-1:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {W{1'b1}};
            check_eq("sb_out", 32'(out_word()), 32'(e));
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive_in(1'b1, 4'd3);

        // Reset: the pipe does not accept, and all outputs are zero.
        tick(); tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_word", 32'(out_word()), 32'd0);
        drive_in(1'b0, 4'd0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Test 1: five back-to-back instructions. out_valid appears after the third edge.
        for (int k = 1; k <= 5; k++) begin
            drive_in(1'b1, 4'(k));
            #1;
            check_eq("t1_in_ready", 32'(in_ready), 32'd1);
            exp_q.push_back(make_word(4'(k)));
            tick();
            check_eq("t1_out_valid", 32'(out_valid), (k >= 3) ? 32'd1 : 32'd0);
        end
        drive_in(1'b0, 4'd0);
        repeat (3) tick();
        check_eq("t1_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t1_idle_valid", 32'(out_valid), 32'd0);

        // Test 2: fill with backpressure, then release for exactly one cycle.
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive_in(1'b1, 4'(k));
            #1;
            check_eq("t2_fill_ready", 32'(in_ready), 32'd1);
            exp_q.push_back(make_word(4'(k)));
            tick();
        end
        drive_in(1'b1, 4'd4);
        #1;
        check_eq("t2_full_ready", 32'(in_ready), 32'd0);
        tick();
        check_eq("t2_hold_head", 32'(out_word()), 32'(make_word(4'd1)));
        out_ready = 1'b1;
        #1;
        check_eq("t2_release_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(make_word(4'd4));
        tick();
        out_ready = 1'b0;
        drive_in(1'b0, 4'd0);
        #1;
        check_eq("t2_new_head", 32'(out_word()), 32'(make_word(4'd2)));
        check_eq("t2_refull_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        check_eq("t2_drained", 32'(exp_q.size()), 32'd0);

        // Test 3: the bubble collapses while the last slot is held.
        out_ready = 1'b0;
        drive_in(1'b1, 4'd11);
        #1;
        check_eq("t3_in_ready_a", 32'(in_ready), 32'd1);
        exp_q.push_back(make_word(4'd11));
        tick();
        drive_in(1'b0, 4'd0);
        tick(); tick();
        check_eq("t3_head_arrived", 32'(out_word()), 32'(make_word(4'd11)));
        drive_in(1'b1, 4'd12);
        #1;
        check_eq("t3_in_ready_b", 32'(in_ready), 32'd1);
        exp_q.push_back(make_word(4'd12));
        tick();
        drive_in(1'b0, 4'd0);
        tick(); tick();
        check_eq("t3_head_kept", 32'(out_word()), 32'(make_word(4'd11)));
        check_eq("t3_slot0_free", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        check_eq("t3_drained", 32'(exp_q.size()), 32'd0);

        // Test 4: flush a full pipe. The transfer on the flush cycle still completes.
        out_ready = 1'b0;
        for (int k = 7; k <= 9; k++) begin
            drive_in(1'b1, 4'(k));
            exp_q.push_back(make_word(4'(k)));
            tick();
        end
        flush = 1'b1;
        out_ready = 1'b1;
        drive_in(1'b1, 4'd10);
        #1;
        check_eq("t4_flush_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        drive_in(1'b0, 4'd0);
        check_eq("t4_flushed_q", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        #1;
        check_eq("t4_out_valid", 32'(out_valid), 32'd0);
        check_eq("t4_out_word", 32'(out_word()), 32'd0);
        check_eq("t4_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        check_eq("t4_no_ghost", 32'(out_valid), 32'd0);

        // Test 5: reset with two valid slots while upstream is presenting.
        out_ready = 1'b0;
        for (int k = 13; k <= 14; k++) begin
            drive_in(1'b1, 4'(k));
            tick();
        end
        reset = 1'b1;
        drive_in(1'b1, 4'd15);
        #1;
        check_eq("t5_rst_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        drive_in(1'b0, 4'd0);
        #1;
        check_eq("t5_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_out_word", 32'(out_word()), 32'd0);
        check_eq("t5_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        check_eq("t5_no_ghost", 32'(out_valid), 32'd0);

`ifdef INSTR_PIPE_REG_STATS_EN
        // Test 6: saturating stall and flush counters.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6_stall_zero", 32'(stall_count), 32'd0);
        check_eq("t6_flush_zero", 32'(flush_count), 32'd0);
        out_ready = 1'b0;
        drive_in(1'b1, 4'd5);
        tick();
        drive_in(1'b0, 4'd0);
        tick(); tick();
        check_eq("t6_stall_start", 32'(stall_count), 32'd0);
        repeat (20) tick();
        check_eq("t6_stall_20", 32'(stall_count), 32'd20);
        repeat (65600) tick();
        check_eq("t6_stall_sat", 32'(stall_count), 32'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("t6_flush_1", 32'(flush_count), 32'd1);
        for (int k = 0; k < 300; k++) begin
            drive_in(1'b1, 4'd6);
            tick();
            drive_in(1'b0, 4'd0);
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        check_eq("t6_flush_sat", 32'(flush_count), 32'hFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6_stall_clr", 32'(stall_count), 32'd0);
        check_eq("t6_flush_clr", 32'(flush_count), 32'd0);
`endif

        // Final report.
        check_eq("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
